mesi_isc_broad_sched: RTL and testbench

// - Round-robin scheduler that serialises main-bus (mbus) requests from 4 cores and sequences coherence-bus (cbus) traffic.
// - Broadcast requests: snoop the 3 other cores, collect their acks, then grant the originator.
// - Sits between the core mbus ports and the shared cbus inside the MESI intersection controller.
// - Exactly one transaction is in flight at a time.

---
 rtl/mesi_isc_broad_sched.sv | 201 ++++++++++++++++++++
 tb/tb_mesi_isc_broad_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_broad_sched.sv
// mesi_isc_broad_sched: round-robin scheduler for four cores' mbus requests.
// Plain reads and writes are acknowledged and finish at once. Broadcasts snoop the
// three other cores, wait for all of their acks, then enable the originating core.
// Only one transaction is in flight at any time.
// Optional watchdog: define MESI_ISC_SCHED_TIMEOUT_EN to abort a SNOOP or ENABLE
// phase that has not finished after TIMEOUT_CYCLES cycles.
// Handshake: a core holds mbus cmd/addr until its 1-cycle mbus ack, then drops the
// cmd the next cycle. A cbus ack from core k completes that core's current cbus
// command; acks that do not match an outstanding command are ignored.
module mesi_isc_broad_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mbus_cmd0_i,
    input  logic [2:0]            mbus_cmd1_i,
    input  logic [2:0]            mbus_cmd2_i,
    input  logic [2:0]            mbus_cmd3_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr0_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr1_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr2_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr3_i,
    output logic                  mbus_ack0_o,
    output logic                  mbus_ack1_o,
    output logic                  mbus_ack2_o,
    output logic                  mbus_ack3_o,
    output logic [2:0]            cbus_cmd0_o,
    output logic [2:0]            cbus_cmd1_o,
    output logic [2:0]            cbus_cmd2_o,
    output logic [2:0]            cbus_cmd3_o,
    output logic [ADDR_WIDTH-1:0] cbus_addr_o,
    input  logic                  cbus_ack0_i,
    input  logic                  cbus_ack1_i,
    input  logic                  cbus_ack2_i,
    input  logic                  cbus_ack3_i,
    output logic                  busy_o,
    output logic [1:0]            grant_id_o,
    output logic                  err_timeout_o
);
    localparam logic [2:0] MB_WR_BROAD = 3'd3;
    localparam logic [2:0] MB_RD_BROAD = 3'd4;
    localparam logic [2:0] CB_NOP      = 3'd0;
    localparam logic [2:0] CB_WR_SNOOP = 3'd1;
    localparam logic [2:0] CB_RD_SNOOP = 3'd2;
    localparam logic [2:0] CB_EN_WR    = 3'd3;
    localparam logic [2:0] CB_EN_RD    = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_SNOOP, S_ENABLE} state_t;

    state_t                state;
    logic [1:0]            ptr;
    logic [1:0]            grant_id;
    logic [2:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            done;

    logic [2:0]            mcmd  [4];
    logic [ADDR_WIDTH-1:0] maddr [4];
    logic [2:0]            cbus_cmd [4];
    logic [3:0]            cack, req, gmask, done_nxt, mbus_ack;
    logic                  all_done, is_wr, is_broad, win_valid, timed_out;
    logic [1:0]            win_id;

    assign mcmd[0]  = mbus_cmd0_i;
    assign mcmd[1]  = mbus_cmd1_i;
    assign mcmd[2]  = mbus_cmd2_i;
    assign mcmd[3]  = mbus_cmd3_i;
    assign maddr[0] = mbus_addr0_i;
    assign maddr[1] = mbus_addr1_i;
    assign maddr[2] = mbus_addr2_i;
    assign maddr[3] = mbus_addr3_i;
    assign cack     = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

    assign mbus_ack0_o = mbus_ack[0];
    assign mbus_ack1_o = mbus_ack[1];
    assign mbus_ack2_o = mbus_ack[2];
    assign mbus_ack3_o = mbus_ack[3];
    assign cbus_cmd0_o = cbus_cmd[0];
    assign cbus_cmd1_o = cbus_cmd[1];
    assign cbus_cmd2_o = cbus_cmd[2];
    assign cbus_cmd3_o = cbus_cmd[3];
    assign busy_o      = (state != S_IDLE);
    assign grant_id_o  = grant_id;

    assign is_wr    = (cmd_q == MB_WR_BROAD);
    assign is_broad = (cmd_q == MB_WR_BROAD) || (cmd_q == MB_RD_BROAD);
    assign gmask    = 4'b0001 << grant_id;
    // Acks from the originator never count towards snoop completion.
    assign done_nxt = done | (cack & ~gmask);
    assign all_done = &(done_nxt | gmask);

    // Valid requests are codes 1..4; 5..7 are treated as NOP.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            req[k] = (mcmd[k] != 3'd0) && (mcmd[k] <= 3'd4);
        end
    end

    // Round-robin pick: the lowest offset after ptr wins, so scan from farthest to nearest.
    always_comb begin
        win_valid = 1'b0;
        win_id    = ptr;
        for (int i = 4; i >= 1; i--) begin
            if (req[ptr + 2'(i)]) begin
                win_valid = 1'b1;
                win_id    = ptr + 2'(i);
            end
        end
    end

    // Decode the mbus accept pulse and per-core cbus commands from the registered state.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mbus_ack[k] = (state == S_ACCEPT) && (grant_id == 2'(k));
            cbus_cmd[k] = CB_NOP;
            if (state == S_SNOOP && grant_id != 2'(k) && !done[k]) begin
                cbus_cmd[k] = is_wr ? CB_WR_SNOOP : CB_RD_SNOOP;
            end else if (state == S_ENABLE && grant_id == 2'(k)) begin
                cbus_cmd[k] = is_wr ? CB_EN_WR : CB_EN_RD;
            end
        end
    end

`ifdef MESI_ISC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tcnt;
    logic             err_q;

    assign timed_out     = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout_o = err_q;

    // Watchdog: cleared on entry to SNOOP/ENABLE, counts every cycle spent there.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timed_out &&
                     ((state == S_SNOOP && !all_done) ||
                      (state == S_ENABLE && !cack[grant_id]));
            if (state == S_ACCEPT || (state == S_SNOOP && all_done)) begin
                tcnt <= '0;
            end else if (state == S_SNOOP || state == S_ENABLE) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
`else
    assign timed_out     = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    // Transaction sequencer: arbitrate, accept, snoop the others, enable the originator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= 2'd3;
            grant_id    <= 2'd0;
            cmd_q       <= 3'd0;
            addr_q      <= '0;
            cbus_addr_o <= '0;
            done        <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        ptr      <= win_id;
                        grant_id <= win_id;
                        cmd_q    <= mcmd[win_id];
                        addr_q   <= maddr[win_id];
                        state    <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (is_broad) begin
                        done        <= 4'd0;
                        cbus_addr_o <= addr_q;
                        state       <= S_SNOOP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SNOOP: begin
                    done <= done_nxt;
                    if (all_done) begin
                        state <= S_ENABLE;
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end
                end
                S_ENABLE: begin
                    if (cack[grant_id] || timed_out) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mesi_isc_broad_sched.sv
// Bench for mesi_isc_broad_sched: directed vector table, a transaction-level
// reference model driven by random requesters/responders, and directed sequences
// for round-robin order, reset during a snoop and (when enabled) the watchdog.
module tb_mesi_isc_broad_sched;
  localparam int TO = 16;
  localparam int M_IDLE = 0, M_ACC = 1, M_SNOOP = 2, M_EN = 3;
  localparam logic [31:0] A1 = 32'h1000_0040;
  localparam logic [31:0] A2 = 32'h0000_0a00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  mcmd  [4];
  logic [31:0] maddr [4];
  logic [3:0]  cack;
  wire  [3:0]  ack;
  wire  [2:0]  cb0, cb1, cb2, cb3;
  wire  [31:0] cbaddr;
  wire         busy, err;
  wire  [1:0]  gid;

  mesi_isc_broad_sched #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mbus_cmd0_i(mcmd[0]), .mbus_cmd1_i(mcmd[1]), .mbus_cmd2_i(mcmd[2]), .mbus_cmd3_i(mcmd[3]),
    .mbus_addr0_i(maddr[0]), .mbus_addr1_i(maddr[1]), .mbus_addr2_i(maddr[2]), .mbus_addr3_i(maddr[3]),
    .mbus_ack0_o(ack[0]), .mbus_ack1_o(ack[1]), .mbus_ack2_o(ack[2]), .mbus_ack3_o(ack[3]),
    .cbus_cmd0_o(cb0), .cbus_cmd1_o(cb1), .cbus_cmd2_o(cb2), .cbus_cmd3_o(cb3),
    .cbus_addr_o(cbaddr),
    .cbus_ack0_i(cack[0]), .cbus_ack1_i(cack[1]), .cbus_ack2_i(cack[2]), .cbus_ack3_i(cack[3]),
    .busy_o(busy), .grant_id_o(gid), .err_timeout_o(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic compare(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, got, want);
    end
  endtask

  function automatic logic [11:0] act_cb();
    return {cb3, cb2, cb1, cb0};
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int          m_state, m_ptr, m_gid, m_cmd, m_cnt;
  logic [31:0] m_addr, m_cbaddr;
  bit          m_done [4];
  bit          m_err;

  function automatic void mdl_reset();
    m_state = M_IDLE; m_ptr = 3; m_gid = 0; m_cmd = 0; m_cnt = 0;
    m_addr = 0; m_cbaddr = 0; m_err = 0;
    for (int k = 0; k < 4; k++) m_done[k] = 0;
  endfunction

  function automatic bit mdl_tmo();
`ifdef MESI_ISC_SCHED_TIMEOUT_EN
    return m_cnt == TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] exp_cb(input int k);
    if (m_state == M_SNOOP && k != m_gid && !m_done[k]) return (m_cmd == 3) ? 3'd1 : 3'd2;
    if (m_state == M_EN && k == m_gid) return (m_cmd == 3) ? 3'd3 : 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [3:0] exp_ackv();
    return (m_state == M_ACC) ? 4'(1 << m_gid) : 4'd0;
  endfunction

  // Advances the model by one clock using the inputs present at the edge.
  function automatic void mdl_step();
    int best, bd, d;
    bit all;
    if (rst) begin
      mdl_reset();
      return;
    end
    m_err = 0;
    case (m_state)
      M_IDLE: begin
        best = -1; bd = 99;
        for (int k = 0; k < 4; k++) begin
          if (mcmd[k] >= 3'd1 && mcmd[k] <= 3'd4) begin
            d = (k - m_ptr + 3) % 4;   // distance after the last winner
            if (d < bd) begin bd = d; best = k; end
          end
        end
        if (best >= 0) begin
          m_ptr = best; m_gid = best; m_cmd = int'(mcmd[best]); m_addr = maddr[best];
          m_state = M_ACC;
        end
      end
      M_ACC: begin
        if (m_cmd >= 3) begin
          m_state = M_SNOOP; m_cnt = 0; m_cbaddr = m_addr;
          for (int k = 0; k < 4; k++) m_done[k] = 0;
        end else begin
          m_state = M_IDLE;
        end
      end
      M_SNOOP: begin
        for (int k = 0; k < 4; k++) if (k != m_gid && cack[k]) m_done[k] = 1;
        all = 1;
        for (int k = 0; k < 4; k++) if (k != m_gid && !m_done[k]) all = 0;
        if (all) begin m_state = M_EN; m_cnt = 0; end
        else if (mdl_tmo()) begin m_state = M_IDLE; m_err = 1; end
        else m_cnt++;
      end
      default: begin
        if (cack[m_gid]) m_state = M_IDLE;
        else if (mdl_tmo()) begin m_state = M_IDLE; m_err = 1; end
        else m_cnt++;
      end
    endcase
  endfunction

  task automatic check_model(input string nm);
    logic [51:0] got, want;
    got  = {ack, act_cb(), busy, gid, err, cbaddr};
    want = {exp_ackv(), exp_cb(3), exp_cb(2), exp_cb(1), exp_cb(0),
            1'(m_state != M_IDLE), 2'(m_gid), m_err, m_cbaddr};
    compare(nm, 64'(got), 64'(want));
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    mdl_step();
    #1;
    check_model(nm);
  endtask

  // ---------------- driver tasks ----------------
  bit drop_nxt [4];
  int req_left [4];

  // Requesters: hold a valid cmd until acked, drop it the cycle after the ack.
  task automatic drive_req(input bit rnd);
    for (int k = 0; k < 4; k++) begin
      if (drop_nxt[k]) begin
        mcmd[k] = 3'd0; drop_nxt[k] = 0;
      end else if (m_state == M_ACC && m_gid == k) begin
        drop_nxt[k] = 1;
      end else if (mcmd[k] >= 3'd1 && mcmd[k] <= 3'd4) begin
        // keep holding
      end else if (rnd) begin
        if ($urandom_range(0, 3) == 0) begin
          mcmd[k] = 3'($urandom_range(0, 7)); maddr[k] = $urandom;
        end else begin
          mcmd[k] = 3'd0;
        end
      end else if (req_left[k] > 0) begin
        mcmd[k] = 3'd4; maddr[k] = 32'h100 * (k + 1); req_left[k]--;
      end
    end
  endtask

  // Responders: random acks (any bit, any time) or prompt acks to outstanding commands.
  task automatic drive_ack(input bit rnd);
    if (rnd) cack = 4'($urandom) & 4'($urandom);
    else for (int k = 0; k < 4; k++) cack[k] = (exp_cb(k) != 3'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cack = 4'd0;
    for (int k = 0; k < 4; k++) begin mcmd[k] = 3'd0; drop_nxt[k] = 0; req_left[k] = 0; end
    tick("rst");
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [11:0] cmd;     // {c3,c2,c1,c0}
    logic [31:0] addr;    // applied to every core
    logic [3:0]  cack;
    logic [3:0]  e_ack;
    logic [11:0] e_cb;    // {cb3,cb2,cb1,cb0}
    logic        e_busy;
    logic [1:0]  e_gid;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt [19];

  function automatic vec_t mk(input logic r, input logic [11:0] c, input logic [31:0] a,
                              input logic [3:0] ca, input logic [3:0] ea, input logic [11:0] ec,
                              input logic eb, input logic [1:0] eg, input logic [31:0] ead);
    vec_t v;
    v.rst = r; v.cmd = c; v.addr = a; v.cack = ca;
    v.e_ack = ea; v.e_cb = ec; v.e_busy = eb; v.e_gid = eg; v.e_addr = ead;
    return v;
  endfunction

  logic [12:0] exp_q [$];
  int n_snoop, n_err, id;

  initial begin
    for (int k = 0; k < 4; k++) begin mcmd[k] = 3'd0; maddr[k] = 32'd0; end
    cack = 4'd0;
    mdl_reset();

    // reset, core1 RD, core3 WR_BROAD, core2 WR_BROAD with mixed acks, invalid cmds
    vt[0]  = mk(1, 12'h000, 0,  4'b0000, 4'b0000, 12'h000, 0, 0, 0);
    vt[1]  = mk(0, 12'h010, 0,  4'b0000, 4'b0010, 12'h000, 1, 1, 0);
    vt[2]  = mk(0, 12'h010, 0,  4'b0000, 4'b0000, 12'h000, 0, 1, 0);
    vt[3]  = mk(0, 12'h000, 0,  4'b0000, 4'b0000, 12'h000, 0, 1, 0);
    vt[4]  = mk(0, 12'h600, A1, 4'b0000, 4'b1000, 12'h000, 1, 3, 0);
    vt[5]  = mk(0, 12'h600, A1, 4'b0000, 4'b0000, 12'h049, 1, 3, A1);
    vt[6]  = mk(0, 12'h000, A1, 4'b0000, 4'b0000, 12'h049, 1, 3, A1);
    vt[7]  = mk(0, 12'h000, A1, 4'b0111, 4'b0000, 12'h600, 1, 3, A1);
    vt[8]  = mk(0, 12'h000, A1, 4'b0000, 4'b0000, 12'h600, 1, 3, A1);
    vt[9]  = mk(0, 12'h000, A1, 4'b1000, 4'b0000, 12'h000, 0, 3, A1);
    vt[10] = mk(0, 12'h0c0, A2, 4'b0000, 4'b0100, 12'h000, 1, 2, A1);
    vt[11] = mk(0, 12'h0c0, A2, 4'b0000, 4'b0000, 12'h209, 1, 2, A2);
    vt[12] = mk(0, 12'h000, A2, 4'b1101, 4'b0000, 12'h008, 1, 2, A2);
    vt[13] = mk(0, 12'h000, A2, 4'b0000, 4'b0000, 12'h008, 1, 2, A2);
    vt[14] = mk(0, 12'h000, A2, 4'b0000, 4'b0000, 12'h008, 1, 2, A2);
    vt[15] = mk(0, 12'h000, A2, 4'b0010, 4'b0000, 12'h0c0, 1, 2, A2);
    vt[16] = mk(0, 12'h000, A2, 4'b0100, 4'b0000, 12'h000, 0, 2, A2);
    vt[17] = mk(0, 12'hfff, A2, 4'b0000, 4'b0000, 12'h000, 0, 2, A2);
    vt[18] = mk(0, 12'h000, 0,  4'b1000, 4'b0000, 12'h000, 0, 2, A2);

    for (int i = 0; i < 19; i++) begin
      rst = vt[i].rst; cack = vt[i].cack;
      for (int k = 0; k < 4; k++) begin mcmd[k] = vt[i].cmd[3*k +: 3]; maddr[k] = vt[i].addr; end
      @(posedge clk);
      #1;
      compare($sformatf("vec%0d", i),
              64'({ack, act_cb(), busy, gid, err, cbaddr}),
              64'({vt[i].e_ack, vt[i].e_cb, vt[i].e_busy, vt[i].e_gid, 1'b0, vt[i].e_addr}));
    end

    // random requesters/responders against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      drive_req(1'b1);
      drive_ack(1'b1);
      tick("rnd");
    end

    // round robin: cores 0,1,2 RD_BROAD, core0 re-requests after its grant
    do_reset();
    req_left[0] = 2; req_left[1] = 1; req_left[2] = 1;
    exp_q = '{13'd0, 13'd1, 13'd2, 13'd0};
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      drive_req(1'b0);
      drive_ack(1'b0);
      tick("rr");
      if (ack != 4'd0) begin
        id = 0;
        for (int k = 0; k < 4; k++) if (ack[k]) id = k;
        compare("rr_grant", 64'(id), 64'(exp_q.pop_front()));
      end
    end
    compare("rr_left", 64'(exp_q.size()), 64'd0);

    // reset while core1's broadcast is snooping; pointer must return to 3
    do_reset();
    req_left[1] = 1;
    for (int c = 0; c < 20 && m_state != M_SNOOP; c++) begin
      drive_req(1'b0);
      cack = 4'd0;
      tick("t5");
    end
    compare("t5_in_snoop", 64'(busy && (cb0 != 3'd0)), 64'd1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin mcmd[k] = 3'd0; drop_nxt[k] = 0; req_left[k] = 0; end
    tick("t5_rst");
    compare("t5_busy", 64'(busy), 64'd0);
    compare("t5_cmds", 64'(act_cb()), 64'd0);
    rst = 1'b0;
    mcmd[1] = 3'd2; maddr[1] = 32'h11;
    mcmd[2] = 3'd2; maddr[2] = 32'h22;
    tick("t5_arb");
    compare("t5_gid", 64'(gid), 64'd1);
    compare("t5_ack", 64'(ack), 64'b0010);
    for (int c = 0; c < 10; c++) begin
      drive_req(1'b0);
      cack = 4'd0;
      tick("t5_drain");
    end
    compare("t5_last_gid", 64'(gid), 64'd2);

`ifdef MESI_ISC_SCHED_TIMEOUT_EN
    // watchdog: core0 RD_BROAD, nobody acks
    do_reset();
    req_left[0] = 1;
    n_snoop = 0; n_err = 0;
    for (int c = 0; c < 60; c++) begin
      drive_req(1'b0);
      cack = 4'd0;
      tick("t6");
      if (cb2 != 3'd0) n_snoop++;
      if (err) n_err++;
    end
    compare("t6_snoop_cycles", 64'(n_snoop), 64'd16);
    compare("t6_err_pulses", 64'(n_err), 64'd1);
    compare("t6_idle", 64'(busy), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
